// File: rtl/cpu_wb.sv
// rtl/cpu_wb.sv - writeback stage merging ALU results with in-order load returns
module cpu_wb #(
    parameter int LDQ_DEPTH = 2
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        ex_we_i,
    input  logic [4:0]  ex_rd_i,
    input  logic [31:0] ex_data_i,
    input  logic        ld_issue_i,
    input  logic [4:0]  ld_rd_i,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_lo_i,
    output logic        ld_issue_ready_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_rready_o,
    output logic        we_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic [31:0] busy_o
);

    localparam int PW = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_CNT = (PW+1)'(LDQ_DEPTH);

    logic [4:0]    q_rd [LDQ_DEPTH];
    logic [2:0]    q_f3 [LDQ_DEPTH];
    logic [1:0]    q_lo [LDQ_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          full, empty, push, pop;

    logic          buf_valid, buf_kill;
    logic [4:0]    buf_rd;
    logic [31:0]   buf_data;
    logic          buf_valid_n, buf_kill_n;
    logic [4:0]    buf_rd_n;
    logic [31:0]   buf_data_n;

    logic          alu_own, kill_now, buf_killed, commit;
    logic [31:0]   busy, busy_n, pend_next;
    logic [LDQ_DEPTH-1:0] ent_valid;

    function automatic logic [31:0] fmt_load(input logic [31:0] w,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*lo +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b100:  fmt_load = {24'd0, b};
            3'b101:  fmt_load = {16'd0, h};
            default: fmt_load = w;
        endcase
    endfunction

    assign full             = (count == DEPTH_CNT);
    assign empty            = (count == '0);
    assign ld_issue_ready_o = !full;
    assign push             = ld_issue_i & !full;

    assign alu_own    = ex_we_i & (ex_rd_i != 5'd0);
    assign kill_now   = buf_valid & alu_own & (ex_rd_i == buf_rd);
    assign buf_killed = buf_kill | kill_now;
    assign commit     = buf_valid & !buf_killed & !alu_own;

    assign mem_rready_o = !empty & (!buf_valid | commit | buf_killed);
    assign pop          = mem_rvalid_i & mem_rready_o;

    always_comb begin
        we_o    = 1'b0;
        waddr_o = 5'd0;
        wdata_o = 32'd0;
        if (alu_own) begin
            we_o    = 1'b1;
            waddr_o = ex_rd_i;
            wdata_o = ex_data_i;
        end else if (commit) begin
            we_o    = 1'b1;
            waddr_o = buf_rd;
            wdata_o = buf_data;
        end
    end

    // A freshly popped response always replaces whatever the buffer held,
    // since the handshake only fires once the old entry is leaving.
    always_comb begin
        buf_valid_n = buf_valid & !(commit | buf_killed);
        buf_kill_n  = buf_kill;
        buf_rd_n    = buf_rd;
        buf_data_n  = buf_data;
        if (pop) begin
            buf_valid_n = 1'b1;
            buf_kill_n  = (q_rd[rd_ptr] == 5'd0);
            buf_rd_n    = q_rd[rd_ptr];
            buf_data_n  = fmt_load(mem_rdata_i, q_f3[rd_ptr], q_lo[rd_ptr]);
        end
    end

    always_comb begin
        for (int i = 0; i < LDQ_DEPTH; i++) begin
            logic [PW-1:0] off;
            off          = PW'(i) - rd_ptr;
            ent_valid[i] = ({1'b0, off} < count);
        end
    end

    // Busy stays set only while some surviving queue entry or live buffer
    // still targets the register; a same-cycle issue always sets it.
    always_comb begin
        pend_next = 32'd0;
        busy_n    = 32'd0;
        for (int r = 1; r < 32; r++) begin
            for (int i = 0; i < LDQ_DEPTH; i++) begin
                if (ent_valid[i] && !(pop && PW'(i) == rd_ptr) && q_rd[i] == 5'(r))
                    pend_next[r] = 1'b1;
            end
            if (buf_valid_n && !buf_kill_n && buf_rd_n == 5'(r))
                pend_next[r] = 1'b1;
            busy_n[r] = (push && ld_rd_i == 5'(r)) || (busy[r] && pend_next[r]);
        end
    end

    assign busy_o = {busy[31:1], 1'b0};

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < LDQ_DEPTH; i++) begin
                q_rd[i] <= 5'd0;
                q_f3[i] <= 3'd0;
                q_lo[i] <= 2'd0;
            end
        end else begin
            if (push) begin
                q_rd[wr_ptr] <= ld_rd_i;
                q_f3[wr_ptr] <= ld_funct3_i;
                q_lo[wr_ptr] <= ld_addr_lo_i;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_kill  <= 1'b0;
            buf_rd    <= 5'd0;
            buf_data  <= 32'd0;
            busy      <= 32'd0;
        end else begin
            buf_valid <= buf_valid_n;
            buf_kill  <= buf_kill_n;
            buf_rd    <= buf_rd_n;
            buf_data  <= buf_data_n;
            busy      <= busy_n;
        end
    end

endmodule
